// File: rtl/tff_down_counter_pkg.sv
// Shared types and constants for the T-FF down counter.
package tff_down_counter_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } cnt_state_t;

endpackage

// File: rtl/tff_down_stage.sv
// One bit of the down counter: T flip-flop with synchronous parallel load
// and a ripple borrow chain (borrow passes through only while this bit is zero).
module tff_down_stage
  import tff_down_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_en,
  input  logic load_bit,
  input  logic toggle_en,
  input  logic borrow_in,
  output logic borrow_out,
  output logic q
);

  logic q_q;
  logic q_d;

  // Load wins over toggle; toggle only when every lower bit is already zero.
  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = load_bit;
    end else if (toggle_en && borrow_in) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign borrow_out = borrow_in & ~q_q;
  assign q          = q_q;

endmodule

// File: rtl/tff_down_counter.sv
// Loadable T-FF ripple-borrow down counter with valid/ready load and done pulse.
// Optional periodic mode: define TFF_DOWN_COUNTER_AUTORELOAD_EN.
module tff_down_counter
  import tff_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  cnt_state_t       state_q;
  cnt_state_t       state_d;
  logic             load_en_c;
  logic [WIDTH-1:0] load_bits_c;
  logic             dec_en_c;
  logic             at_one_c;
  logic             q_zero_c;
  logic [WIDTH:0]   borrow;

`ifdef TFF_DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
`endif

  assign at_one_c = (q == WIDTH'(1));
  assign q_zero_c = borrow[WIDTH];

  // Next state, stage load/decrement controls.
  always_comb begin
    state_d     = state_q;
    load_en_c   = 1'b0;
    load_bits_c = load_value;
    dec_en_c    = 1'b0;
`ifdef TFF_DOWN_COUNTER_AUTORELOAD_EN
    reload_d    = reload_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          load_en_c = 1'b1;
          state_d   = (load_value != '0) ? RUN : DONE;
`ifdef TFF_DOWN_COUNTER_AUTORELOAD_EN
          reload_d  = load_value;
`endif
        end
      end
      RUN: begin
        // Abort beats terminal count; a zero count never decrements (no wrap).
        if (abort) begin
          state_d  = IDLE;
`ifdef TFF_DOWN_COUNTER_AUTORELOAD_EN
          reload_d = '0;
`endif
        end else if (q_zero_c) begin
          state_d = DONE;
        end else if (count_en) begin
          dec_en_c = 1'b1;
          if (at_one_c) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef TFF_DOWN_COUNTER_AUTORELOAD_EN
        if (abort) begin
          reload_d = '0;
        end else if (reload_q != '0) begin
          load_en_c   = 1'b1;
          load_bits_c = reload_q;
          state_d     = RUN;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef TFF_DOWN_COUNTER_AUTORELOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    tff_down_stage u_stage (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en_c),
      .load_bit   (load_bits_c[i]),
      .toggle_en  (dec_en_c),
      .borrow_in  (borrow[i]),
      .borrow_out (borrow[i+1]),
      .q          (q[i])
    );
  end

  assign load_ready = (state_q == IDLE) && !rst;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_tff_down_counter.sv
// Bench for tff_down_counter: vector table plus scoreboard queue, with
// hand-written reset, completion and (when enabled) auto-reload sequences.
module tb_tff_down_counter;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;
  logic         count_en;
  logic         abort;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  typedef struct {
    logic         lv;
    logic [W-1:0] lval;
    logic         ce;
    logic         ab;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         rdy;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         rdy;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[20];
  int   checks = 0;
  int   errors = 0;

  tff_down_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .count_en   (count_en),
    .abort      (abort),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input int lv, input int lval, input int ce, input int ab,
                              input int eq, input int eb, input int ed, input int er);
    vec_t v;
    v.lv   = 1'(lv);
    v.lval = W'(lval);
    v.ce   = 1'(ce);
    v.ab   = 1'(ab);
    v.q    = W'(eq);
    v.busy = 1'(eb);
    v.done = 1'(ed);
    v.rdy  = 1'(er);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    load_valid = v.lv;
    load_value = v.lval;
    count_en   = v.ce;
    abort      = v.ab;
    e.q    = v.q;
    e.busy = v.busy;
    e.done = v.done;
    e.rdy  = v.rdy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".q"},    int'(q),          int'(got.q));
    chk({tag, ".busy"}, int'(busy),       int'(got.busy));
    chk({tag, ".done"}, int'(done),       int'(got.done));
    chk({tag, ".rdy"},  int'(load_ready), int'(got.rdy));
  endtask

  initial begin
    //            lv lval ce ab   q  bsy dn rdy
    tbl[0]  = mk(1,  3,  1, 0,   3, 1, 0, 0);
    tbl[1]  = mk(0,  0,  1, 0,   2, 1, 0, 0);
    tbl[2]  = mk(0,  0,  1, 0,   1, 1, 0, 0);
    tbl[3]  = mk(0,  0,  1, 0,   0, 0, 1, 0);
    tbl[4]  = mk(0,  0,  0, 1,   0, 0, 0, 1);
    tbl[5]  = mk(1, 15,  0, 0,  15, 1, 0, 0);
    tbl[6]  = mk(0,  0,  1, 0,  14, 1, 0, 0);
    tbl[7]  = mk(0,  0,  0, 0,  14, 1, 0, 0);
    tbl[8]  = mk(0,  0,  1, 0,  13, 1, 0, 0);
    tbl[9]  = mk(0,  0,  0, 0,  13, 1, 0, 0);
    tbl[10] = mk(0,  0,  1, 1,  13, 0, 0, 1);
    tbl[11] = mk(1,  0,  0, 0,   0, 0, 1, 0);
    tbl[12] = mk(0,  0,  0, 0,   0, 0, 0, 1);
    tbl[13] = mk(1,  5,  1, 0,   5, 1, 0, 0);
    tbl[14] = mk(0,  0,  1, 0,   4, 1, 0, 0);
    tbl[15] = mk(1,  9,  1, 0,   3, 1, 0, 0);
    tbl[16] = mk(0,  0,  1, 0,   2, 1, 0, 0);
    tbl[17] = mk(0,  0,  1, 0,   1, 1, 0, 0);
    tbl[18] = mk(0,  0,  1, 1,   1, 0, 0, 1);
    tbl[19] = mk(0,  0,  0, 1,   1, 0, 0, 1);

    rst        = 1'b1;
    load_valid = 1'b0;
    load_value = '0;
    count_en   = 1'b0;
    abort      = 1'b0;

    #12;
    chk("reset.q",    int'(q),          0);
    chk("reset.busy", int'(busy),       0);
    chk("reset.done", int'(done),       0);
    chk("reset.rdy",  int'(load_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset.rdy", int'(load_ready), 1);

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

`ifdef TFF_DOWN_COUNTER_AUTORELOAD_EN
    apply(mk(1, 2, 1, 0, 2, 1, 0, 0), "auto_load");
    apply(mk(0, 0, 1, 0, 1, 1, 0, 0), "auto_c1");
    apply(mk(0, 0, 1, 0, 0, 0, 1, 0), "auto_done1");
    apply(mk(0, 0, 1, 0, 2, 1, 0, 0), "auto_reload1");
    apply(mk(0, 0, 1, 0, 1, 1, 0, 0), "auto_c2");
    apply(mk(0, 0, 1, 0, 0, 0, 1, 0), "auto_done2");
    apply(mk(0, 0, 1, 0, 2, 1, 0, 0), "auto_reload2");
    apply(mk(0, 0, 1, 1, 2, 0, 0, 1), "auto_abort");
    apply(mk(0, 0, 1, 0, 2, 0, 0, 1), "auto_idle");
`else
    apply(mk(1, 1, 1, 0, 1, 1, 0, 0), "one_load");
    apply(mk(0, 0, 1, 0, 0, 0, 1, 0), "one_done");
    apply(mk(0, 0, 1, 0, 0, 0, 0, 1), "one_idle");
`endif

    // Asynchronous reset in the middle of a count, away from any clock edge.
    apply(mk(1, 9, 1, 0, 9, 1, 0, 0), "arst_load");
    apply(mk(0, 0, 1, 0, 8, 1, 0, 0), "arst_c1");
    apply(mk(0, 0, 1, 0, 7, 1, 0, 0), "arst_c2");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.q",    int'(q),          0);
    chk("arst.busy", int'(busy),       0);
    chk("arst.done", int'(done),       0);
    chk("arst.rdy",  int'(load_ready), 0);
    @(posedge clk);
    #1;
    chk("arst_hold.rdy",  int'(load_ready), 0);
    chk("arst_hold.done", int'(done),       0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_release.rdy", int'(load_ready), 1);
    chk("arst_release.q",   int'(q),          0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
